imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have exactly one clock, clk, and one reset, rst; rst SHALL be asynchronous and active-high.
REQ-002 Parameter: DEPTH, 1000, instruction-memory depth in 32-bit words.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: start  input  1  one-cycle pulse that begins a load.
REQ-006 Port: word_count  input  10  number of words to load, sampled on start.
REQ-007 Port: abort  input  1  cancels an in-progress load.
REQ-008 Port: byte_in  input  8  incoming program byte.
REQ-009 Port: byte_valid  input  1  byte_in is valid.
REQ-010 Port: byte_ready  output  1  loader can accept a byte.
REQ-011 Port: we  output  1  instruction-memory write enable.
REQ-012 Port: waddr  output  32  byte address of the write, word-aligned.
REQ-013 Port: wdata  output  32  instruction word to write.
REQ-014 Port: busy  output  1  load in progress.
REQ-015 Port: done  output  1  last load completed successfully.
REQ-016 Port: err  output  1  last start request was rejected.
REQ-017 Port: cpu_hold  output  1  holds the processor in reset while high.

Function
REQ-018 FSM states SHALL be IDLE, RECV, WRITE and DONE.
REQ-019 A byte SHALL transfer only on a clock edge where byte_valid and byte_ready are both high; byte_ready SHALL be high only in RECV.
REQ-020 In IDLE or DONE, start with word_count in 1..DEPTH SHALL latch word_count, clear word index, byte index, done and err, and enter RECV on the next edge.
REQ-021 In IDLE or DONE, start with word_count of 0 or greater than DEPTH SHALL set err to 1, clear done, and leave the state unchanged.
REQ-022 start in RECV or WRITE SHALL be ignored.
REQ-023 Bytes SHALL assemble little-endian: byte k of a word (k = 0..3) goes to wdata[8k+7:8k].
REQ-024 The edge that accepts byte 3 SHALL enter WRITE.
REQ-025 we SHALL be high for exactly the one cycle spent in WRITE; waddr SHALL equal word_index*4 and wdata SHALL hold the assembled word for that cycle.
REQ-026 On leaving WRITE, word_index SHALL increment; the next state SHALL be DONE if word_index was latched_count-1, otherwise RECV.
REQ-027 In DONE: done = 1, cpu_hold = 0, busy = 0, and the state SHALL persist until start or rst.
REQ-028 busy SHALL be 1 exactly in RECV and WRITE.
REQ-029 cpu_hold SHALL be 1 in every state except DONE.
REQ-030 abort in RECV or WRITE SHALL return the FSM to IDLE on the next edge, suppress any pending we, discard the partial word, and leave done and err at 0.
REQ-031 If abort and start are high in the same cycle, abort SHALL take priority.
REQ-032 abort in IDLE or DONE SHALL have no effect.
REQ-033 The largest waddr SHALL be (DEPTH-1)*4; the word index SHALL never wrap.

Reset
REQ-034 rst SHALL immediately force state IDLE and set byte_ready, we, waddr, wdata, busy, done and err to 0, cpu_hold to 1, and clear all counters.
REQ-035 rst asserted mid-load SHALL abandon the load without producing any further we pulse.

Structure
REQ-036 FSM state encodings and the DEPTH default SHALL reside in shared package mips_pkg.
REQ-037 One sub-module, imem_word_packer (byte-to-word assembler with byte counter), SHALL be used.
REQ-038 All outputs SHALL be driven from registers or decoded from the state register only, with no combinational path from inputs.

Verification
REQ-039 Start with word_count=2, then bytes 0x13,0x00,0x00,0x20,0x08,0x00,0x00,0x00 with continuous valid -> we pulses with (waddr 0x0, wdata 0x20000013) and (0x4, 0x00000008); then done=1 and cpu_hold=0.
REQ-040 Start with word_count=0, and separately with word_count=1001 -> err=1, state stays IDLE, no we, byte_ready=0.
REQ-041 Abort asserted after 6 of 8 bytes -> one we (address 0x0) only; state returns to IDLE, done=0, cpu_hold=1.
REQ-042 Start and abort asserted together while in RECV -> IDLE on the next edge; start ignored.
REQ-043 rst pulsed between bytes 2 and 3 -> all outputs at reset values immediately; no we afterwards.
REQ-044 Load word_count=1000 with random byte_valid gaps -> final we at waddr 0xF9C, then DONE; total we count exactly 1000.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the instruction-memory loader
//
// Purpose: loader FSM state encoding, default instruction-memory depth and a
//          word-index to byte-address helper.
// Ports:   none (package).
package mips_pkg;

    localparam int IMEM_DEPTH = 1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

    // Word index to byte address: waddr is always word-aligned.
    function automatic logic [31:0] word_byte_addr(input logic [9:0] idx);
        return {20'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - little-endian byte-to-word assembler with byte counter
//
// Purpose: collects four bytes into one 32-bit word, byte k into bits [8k+7:8k].
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   clear      drop any partial word and restart at byte 0 (wins over accept)
//   accept     byte_in is consumed this edge
//   byte_in    incoming byte
//   word       assembled word (holds its value after the fourth byte)
//   byte_idx   position the next accepted byte will fill
module imem_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [1:0]  byte_idx
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word     <= 32'd0;
            byte_idx <= 2'd0;
        end else if (clear) begin
            word     <= 32'd0;
            byte_idx <= 2'd0;
        end else if (accept) begin
            case (byte_idx)
                2'd0:    word[7:0]   <= byte_in;
                2'd1:    word[15:8]  <= byte_in;
                2'd2:    word[23:16] <= byte_in;
                default: word[31:24] <= byte_in;
            endcase
            // Two-bit counter wraps to 0 after byte 3, ready for the next word.
            byte_idx <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams program bytes into instruction memory while holding the CPU
//
// Purpose: on start, receives word_count little-endian 32-bit words as a byte
//          stream and writes each to instruction memory; releases cpu_hold
//          once the whole image is written.
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   start        one-cycle pulse beginning a load (ignored while busy)
//   word_count   number of words to load, sampled on start (1..DEPTH valid)
//   abort        cancels an in-progress load
//   byte_in      program byte; byte_valid qualifies it
//   byte_ready   loader accepts a byte this cycle
//   we/waddr/wdata  instruction-memory write port (byte address, word-aligned)
//   busy         load in progress
//   done         last load completed
//   err          last start request was rejected
//   cpu_hold     processor held in reset while high
module imem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  word_count,
    input  logic        abort,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_hold
);

    localparam logic [10:0] DEPTH_W = 11'(DEPTH);

    loader_state_t state;
    logic [9:0]    word_idx;
    logic [9:0]    latched_count;
    logic [1:0]    byte_idx;
    logic          idle_like;
    logic          count_ok;
    logic          start_ok;
    logic          accept;
    logic          last_byte;
    logic          packer_clear;

    assign idle_like    = (state == ST_IDLE) || (state == ST_DONE);
    assign count_ok     = (word_count != 10'd0) && ({1'b0, word_count} <= DEPTH_W);
    assign start_ok     = idle_like && start && count_ok;
    assign accept       = (state == ST_RECV) && byte_valid;
    assign last_byte    = accept && (byte_idx == 2'd3);
    // abort discards the partial word; a fresh start also begins from byte 0.
    assign packer_clear = start_ok || (abort && !idle_like);

    imem_word_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (packer_clear),
        .accept   (accept),
        .byte_in  (byte_in),
        .word     (wdata),
        .byte_idx (byte_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            word_idx      <= 10'd0;
            latched_count <= 10'd0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (count_ok) begin
                            latched_count <= word_count;
                            word_idx      <= 10'd0;
                            done          <= 1'b0;
                            err           <= 1'b0;
                            state         <= ST_RECV;
                        end else begin
                            err  <= 1'b1;
                            done <= 1'b0;
                        end
                    end
                end
                ST_RECV: begin
                    // Abort wins over completing a word, so no write is issued.
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (last_byte) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        word_idx <= word_idx + 10'd1;
                        if (word_idx == latched_count - 10'd1) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RECV;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from state or taken straight from registers.
    assign byte_ready = (state == ST_RECV);
    assign we         = (state == ST_WRITE);
    assign busy       = (state == ST_RECV) || (state == ST_WRITE);
    assign cpu_hold   = (state != ST_DONE);
    assign waddr      = word_byte_addr(word_idx);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  word_count = 10'd0;
    logic        abort = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(1000)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .abort      (abort),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_hold   (cpu_hold)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Model: expected writes derived from the byte stream as it is accepted.
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] part_word;
    int          part_cnt;
    int          word_no;

    // Observed writes.
    int          we_count = 0;
    logic [31:0] last_waddr = 32'd0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    function automatic void model_restart();
        part_word = 32'd0;
        part_cnt  = 0;
        word_no   = 0;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (we) begin
                we_count++;
                last_waddr = waddr;
                log_addr.push_back(waddr);
                log_data.push_back(wdata);
                chk("we_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) begin
                    chk("we_addr", waddr, exp_addr_q.pop_front());
                    chk("we_data", wdata, exp_data_q.pop_front());
                end
                chk("we_busy", 32'(busy), 32'd1);
                chk("we_no_ready", 32'(byte_ready), 32'd0);
            end
            if (done) begin
                chk("done_cpu_free", 32'(cpu_hold), 32'd0);
                chk("done_not_busy", 32'(busy), 32'd0);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_we"}, 32'(we), 32'd0);
        chk({tag, "_waddr"}, waddr, 32'd0);
        chk({tag, "_wdata"}, wdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    endtask

    task automatic begin_load(input logic [9:0] n);
        word_count = n;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        model_restart();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        logic ok;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        byte_in    = b;
        byte_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            rdy = byte_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        chk("byte_accept", 32'(ok), 32'd1);
        if (ok) begin
            case (part_cnt)
                0:       part_word[7:0]   = b;
                1:       part_word[15:8]  = b;
                2:       part_word[23:16] = b;
                default: part_word[31:24] = b;
            endcase
            part_cnt++;
            if (part_cnt == 4) begin
                exp_addr_q.push_back(32'(word_no * 4));
                exp_data_q.push_back(part_word);
                word_no++;
                part_cnt  = 0;
                part_word = 32'd0;
            end
        end
    endtask

    task automatic wait_done(input int lim);
        for (int t = 0; t < lim && !done; t++) @(negedge clk);
        chk("done_reached", 32'(done), 32'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_restart();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b39 [8];
        int base_we;
        int base_log;
        b39 = '{8'h13, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h00, 8'h00};
        model_restart();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // Two-word load with continuous valid
        base_we  = we_count;
        base_log = log_addr.size();
        begin_load(10'd2);
        for (int i = 0; i < 8; i++) send_byte(b39[i], 0);
        byte_valid = 1'b0;
        wait_done(20);
        chk("load2_we_count", 32'(we_count - base_we), 32'd2);
        if (log_addr.size() >= base_log + 2) begin
            chk("load2_addr0", log_addr[base_log], 32'h0);
            chk("load2_data0", log_data[base_log], 32'h20000013);
            chk("load2_addr1", log_addr[base_log + 1], 32'h4);
            chk("load2_data1", log_data[base_log + 1], 32'h00000008);
        end
        chk("load2_done", 32'(done), 32'd1);
        chk("load2_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("load2_busy", 32'(busy), 32'd0);
        chk("load2_err", 32'(err), 32'd0);

        // Rejected word counts from IDLE
        pulse_reset();
        base_we = we_count;
        begin_load(10'd0);
        @(negedge clk);
        chk("wc0_err", 32'(err), 32'd1);
        chk("wc0_busy", 32'(busy), 32'd0);
        chk("wc0_ready", 32'(byte_ready), 32'd0);
        chk("wc0_hold", 32'(cpu_hold), 32'd1);
        pulse_reset();
        begin_load(10'd1001);
        repeat (3) @(negedge clk);
        chk("wc1001_err", 32'(err), 32'd1);
        chk("wc1001_busy", 32'(busy), 32'd0);
        chk("wc1001_ready", 32'(byte_ready), 32'd0);
        chk("wc1001_done", 32'(done), 32'd0);
        chk("reject_no_we", 32'(we_count - base_we), 32'd0);

        // Abort after 6 of 8 bytes
        @(posedge clk);
        #1;
        base_we = we_count;
        begin_load(10'd2);
        chk("abort_err_cleared", 32'(err), 32'd0);
        for (int i = 0; i < 6; i++) send_byte(b39[i], 0);
        byte_valid = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        model_restart();
        repeat (5) @(negedge clk);
        chk("abort_we_count", 32'(we_count - base_we), 32'd1);
        chk("abort_last_addr", last_waddr, 32'h0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_hold", 32'(cpu_hold), 32'd1);
        chk("abort_ready", 32'(byte_ready), 32'd0);

        // Start and abort together while receiving
        @(posedge clk);
        #1;
        begin_load(10'd1);
        send_byte(8'hAA, 0);
        byte_valid = 1'b0;
        word_count = 10'd3;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        model_restart();
        @(negedge clk);
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_ready", 32'(byte_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("sa_still_idle", 32'(busy), 32'd0);

        // Reset between bytes 2 and 3
        @(posedge clk);
        #1;
        base_we = we_count;
        begin_load(10'd2);
        for (int i = 0; i < 3; i++) send_byte(b39[i], 0);
        byte_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        model_restart();
        byte_in = 8'h55;
        byte_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1 byte_valid = 1'b0;
        chk("midrst_no_we", 32'(we_count - base_we), 32'd0);
        chk("midrst_ready", 32'(byte_ready), 32'd0);

        // Full-depth load with random gaps
        base_we = we_count;
        begin_load(10'd1000);
        for (int i = 0; i < 4000; i++) begin
            int gap;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_byte(8'(i * 7 + 3), gap);
        end
        byte_valid = 1'b0;
        wait_done(20);
        chk("full_we_count", 32'(we_count - base_we), 32'd1000);
        chk("full_last_waddr", last_waddr, 32'h00000F9C);
        chk("full_done", 32'(done), 32'd1);
        chk("full_queue_empty", 32'(exp_addr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
